// File: rtl/seg_chaser_pkg.sv
// seg_chaser_pkg: segment bit indices, mode encodings and path-length helper for seg_chaser.
package seg_chaser_pkg;
  localparam logic [2:0] SEG_A  = 3'd0;
  localparam logic [2:0] SEG_B  = 3'd1;
  localparam logic [2:0] SEG_C  = 3'd2;
  localparam logic [2:0] SEG_D  = 3'd3;
  localparam logic [2:0] SEG_E  = 3'd4;
  localparam logic [2:0] SEG_F  = 3'd5;
  localparam logic [2:0] SEG_G  = 3'd6;
  localparam logic [2:0] SEG_DP = 3'd7;
  localparam logic MODE_SPIN  = 1'b0;
  localparam logic MODE_PERIM = 1'b1;
  function automatic int perim_len(input int n);
    return 2 * n + 4;
  endfunction
endpackage

// File: rtl/chaser_tick_gen.sv
// chaser_tick_gen: prescaler emitting one step pulse every STEP_DIV<<speed cycles.
module chaser_tick_gen #(
  parameter int STEP_DIV = 5_000_000
) (
  input  logic       inclk,
  input  logic       reset,
  input  logic       pause,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       step
);
  localparam int CW = $clog2(STEP_DIV) + 4;
  logic [CW-1:0] cnt_q, cnt_d, top;
  always_comb begin
    top = (CW'(STEP_DIV) << speed) - CW'(1);
    step = !clear && !pause && cnt_q >= top;
    cnt_d = (clear || step) ? '0 : pause ? cnt_q : cnt_q + CW'(1);
  end
  always_ff @(posedge inclk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_chaser.sv
// seg_chaser: one-segment spin/perimeter animation driving a multiplexed seven-segment display.
module seg_chaser import seg_chaser_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int STEP_DIV   = 5_000_000,
  parameter bit ACTIVE_LOW = 1'b1,
  localparam int POS_W     = $clog2(2 * NUM_DIGITS + 4)
) (
  input  logic                  inclk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  dir,
  input  logic                  pause,
  input  logic [1:0]            speed,
  input  logic [2:0]            digit_sel,
  output logic [7:0]            segment,
  output logic [NUM_DIGITS-1:0] enable,
  output logic [POS_W-1:0]      pos,
  output logic                  wrap
);
  localparam logic [POS_W-1:0] LAST_SPIN  = POS_W'(5);
  localparam logic [POS_W-1:0] LAST_PERIM = POS_W'(perim_len(NUM_DIGITS) - 1);
  localparam logic [POS_W-1:0] P_LM = POS_W'(NUM_DIGITS - 1);
  localparam logic [POS_W-1:0] P_B  = POS_W'(NUM_DIGITS);
  localparam logic [POS_W-1:0] P_C  = POS_W'(NUM_DIGITS + 1);
  localparam logic [POS_W-1:0] P_D0 = POS_W'(NUM_DIGITS + 2);
  localparam logic [POS_W-1:0] P_DL = POS_W'(2 * NUM_DIGITS + 1);
  localparam logic [POS_W-1:0] P_E  = POS_W'(2 * NUM_DIGITS + 2);
  localparam logic [2:0] DIG_L = 3'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = ACTIVE_LOW ? '1 : '0;
  logic mode_q, mode_chg, step, wrapped_q, wrapped_d, wrap_q;
  logic [POS_W-1:0] pos_q, pos_d, last, pos_o_q;
  logic [2:0] sel, dig, s;
  logic [7:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  chaser_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .inclk(inclk),
    .reset(reset),
    .pause(pause),
    .clear(mode_chg),
    .speed(speed),
    .step (step)
  );
  always_comb begin
    mode_chg = mode != mode_q;
    last = (mode == MODE_PERIM) ? LAST_PERIM : LAST_SPIN;
    pos_d = pos_q;
    wrapped_d = 1'b0;
    if (mode_chg) pos_d = '0;
    else if (step) begin
      pos_d = dir ? ((pos_q == last) ? '0 : pos_q + POS_W'(1)) : ((pos_q == '0) ? last : pos_q - POS_W'(1));
      wrapped_d = dir ? pos_q == last : pos_q == '0;
    end
  end
  // Decode uses mode_q: it is the mode under which pos_q was computed.
  always_comb begin
    sel = ({1'b0, digit_sel} >= 4'(NUM_DIGITS)) ? DIG_L : digit_sel;
    dig = '0;
    s = SEG_F;
    if (mode_q == MODE_SPIN) begin
      dig = sel;
      s = 3'(pos_q);
    end else if (pos_q < P_B) begin
      dig = 3'(P_LM - pos_q);
      s = SEG_A;
    end else if (pos_q == P_B) s = SEG_B;
    else if (pos_q == P_C) s = SEG_C;
    else if (pos_q <= P_DL) begin
      dig = 3'(pos_q - P_D0);
      s = SEG_D;
    end else begin
      dig = DIG_L;
      s = (pos_q == P_E) ? SEG_E : SEG_F;
    end
    seg_d = SEG_OFF ^ (8'(1) << s);
    en_d = EN_OFF ^ (NUM_DIGITS'(1) << dig);
  end
  always_ff @(posedge inclk) begin
    mode_q <= mode;
    if (reset) begin
      pos_q <= '0;
      wrapped_q <= 1'b0;
      seg_q <= SEG_OFF;
      en_q <= EN_OFF;
      pos_o_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      wrapped_q <= wrapped_d;
      seg_q <= seg_d;
      en_q <= en_d;
      pos_o_q <= pos_q;
      wrap_q <= wrapped_q;
    end
  end
  assign segment = seg_q;
  assign enable = en_q;
  assign pos = pos_o_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_seg_chaser.sv
// tb_seg_chaser: directed and random checks of two seg_chaser builds against a path-table model.
module tb_seg_chaser;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, mode = 1'b0, dir = 1'b0, pause = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [2:0] digit_sel = 3'd0;
  logic [7:0] seg0, seg1;
  logic [3:0] en0, pos0;
  logic [0:0] en1;
  logic [2:0] pos1;
  logic wrap0, wrap1;
  int n_tests = 0, n_fail = 0;
  int nd[2] = '{4, 1};
  bit al[2] = '{1'b1, 1'b0};
  int m_cnt = 0;
  bit m_mprev = 1'b0;
  int m_pos[2] = '{0, 0};
  bit m_wrp[2] = '{1'b0, 1'b0};
  int e_seg[2], e_en[2], e_pos[2];
  bit e_wrap[2];

  seg_chaser #(.NUM_DIGITS(4), .STEP_DIV(4), .ACTIVE_LOW(1'b1)) u0 (
    .inclk(clk), .reset(reset), .mode(mode), .dir(dir), .pause(pause), .speed(speed),
    .digit_sel(digit_sel), .segment(seg0), .enable(en0), .pos(pos0), .wrap(wrap0));
  seg_chaser #(.NUM_DIGITS(1), .STEP_DIV(4), .ACTIVE_LOW(1'b0)) u1 (
    .inclk(clk), .reset(reset), .mode(mode), .dir(dir), .pause(pause), .speed(speed),
    .digit_sel(digit_sel), .segment(seg1), .enable(en1), .pos(pos1), .wrap(wrap1));

  // The lit (digit, segment) sequence is rebuilt by walking the display outline.
  task automatic path(input int k, input bit m, output int dg[$], output int sg[$]);
    int n = nd[k];
    dg = {};
    sg = {};
    if (!m) begin
      for (int i = 0; i < 6; i++) begin
        dg.push_back(digit_sel >= n ? n - 1 : int'(digit_sel));
        sg.push_back(i);
      end
    end else begin
      for (int d = n - 1; d >= 0; d--) begin dg.push_back(d); sg.push_back(0); end
      dg.push_back(0); sg.push_back(1);
      dg.push_back(0); sg.push_back(2);
      for (int d = 0; d < n; d++) begin dg.push_back(d); sg.push_back(3); end
      dg.push_back(n - 1); sg.push_back(4);
      dg.push_back(n - 1); sg.push_back(5);
    end
  endtask

  task automatic tick();
    int dg[$], sg[$], len;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int all = (1 << nd[k]) - 1;
      if (reset) begin
        e_seg[k] = al[k] ? 255 : 0;
        e_en[k] = al[k] ? all : 0;
        e_pos[k] = 0;
        e_wrap[k] = 1'b0;
      end else begin
        path(k, m_mprev, dg, sg);
        e_seg[k] = al[k] ? 255 ^ (1 << sg[m_pos[k]]) : 1 << sg[m_pos[k]];
        e_en[k] = al[k] ? all ^ (1 << dg[m_pos[k]]) : 1 << dg[m_pos[k]];
        e_pos[k] = m_pos[k];
        e_wrap[k] = m_wrp[k];
      end
    end
    if (reset || mode != m_mprev) begin
      m_cnt = 0;
      m_pos = '{0, 0};
      m_wrp = '{1'b0, 1'b0};
    end else if (pause) m_wrp = '{1'b0, 1'b0};
    else if (m_cnt >= (4 << speed) - 1) begin
      m_cnt = 0;
      for (int k = 0; k < 2; k++) begin
        path(k, mode, dg, sg);
        len = dg.size();
        m_wrp[k] = dir ? m_pos[k] == len - 1 : m_pos[k] == 0;
        m_pos[k] = dir ? (m_pos[k] + 1) % len : (m_pos[k] + len - 1) % len;
      end
    end else begin
      m_cnt++;
      m_wrp = '{1'b0, 1'b0};
    end
    m_mprev = mode;
    #1;
  endtask

  task automatic chk(input string tag);
    n_tests++;
    assert (seg0 === 8'(e_seg[0]) && en0 === 4'(e_en[0]) && pos0 === 4'(e_pos[0]) && wrap0 === e_wrap[0])
    else begin
      n_fail++;
      $error("FAIL %s n4: got seg=%h en=%b pos=%0d wrap=%b, want seg=%h en=%b pos=%0d wrap=%b",
             tag, seg0, en0, pos0, wrap0, 8'(e_seg[0]), 4'(e_en[0]), e_pos[0], e_wrap[0]);
    end
    n_tests++;
    assert (seg1 === 8'(e_seg[1]) && en1 === 1'(e_en[1]) && pos1 === 3'(e_pos[1]) && wrap1 === e_wrap[1])
    else begin
      n_fail++;
      $error("FAIL %s n1: got seg=%h en=%b pos=%0d wrap=%b, want seg=%h en=%b pos=%0d wrap=%b",
             tag, seg1, en1, pos1, wrap1, 8'(e_seg[1]), 1'(e_en[1]), e_pos[1], e_wrap[1]);
    end
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin tick(); chk(tag); end
  endtask

  // Advance until the model reaches pos p (of the 4-digit build) and count c; negative means any.
  task automatic reach(input int p, input int c, input string tag);
    int g = 0;
    while (!((p < 0 || m_pos[0] == p) && (c < 0 || m_cnt == c)) && g < 300) begin
      tick();
      chk(tag);
      g++;
    end
    n_tests++;
    assert (g < 300) else begin
      n_fail++;
      $error("FAIL %s reach: got timeout after %0d cycles, want pos=%0d cnt=%0d", tag, g, p, c);
    end
  endtask

  initial begin
    #1;
    run(3, "reset");
    reset = 1'b0;
    run(30, "spin_ccw");
    mode = 1'b1;
    dir = 1'b1;
    run(60, "perim_cw");
    reach(3, 1, "to_pause");
    pause = 1'b1;
    run(20, "paused");
    pause = 1'b0;
    run(10, "unpause");
    mode = 1'b0;
    run(5, "back_spin");
    reach(5, 3, "to_mode");
    mode = 1'b1;
    run(10, "mode_chg");
    speed = 2'd3;
    reach(-1, 10, "to_speed");
    speed = 2'd0;
    run(3, "speed_drop");
    mode = 1'b0;
    digit_sel = 3'd6;
    run(8, "dsel_clamp");
    mode = 1'b1;
    reach(7, -1, "to_reset");
    reset = 1'b1;
    run(1, "reset_mid");
    reset = 1'b0;
    run(10, "after_reset");
    repeat (1500) begin
      if ($urandom_range(39) == 0) mode = ~mode;
      if ($urandom_range(29) == 0) dir = ~dir;
      if ($urandom_range(19) == 0) pause = ~pause;
      if ($urandom_range(29) == 0) speed = 2'($urandom_range(3));
      if ($urandom_range(9) == 0) digit_sel = 3'($urandom_range(7));
      reset = ($urandom_range(199) == 0);
      tick();
      chk("random");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
